wb_result_fifo: RTL

Wishbone B4 classic responder that buffers 32-bit measurement results between the control unit (initiator) and the rest of the bus. The control unit pushes words by writing DATA and drains them by reading DATA; STATUS and CTRL expose fill level, flags and flush. It sits on the shared bus next to the UART and frequency-counter responders. Its dat_o, err_o and rty_o are OR-combined with theirs, so it drives zero whenever it is not responding.

---
 rtl/wb_result_fifo.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: Wishbone B4 classic responder buffering 32-bit results in a circular FIFO.
// Ports: clk_i/rst_i (sync, active-low), addr_i/dat_i/we_i/sel_i/cyc_i/stb_i request,
//        dat_o/ack_o/err_o/rty_o registered termination (all zero when not responding),
//        lock_i/tagn_i ignored, tagn_o tied 0.
// Registers: 0x0 DATA push/pop, 0x4 STATUS, 0x8 CTRL (bit0 flush, bit1 clear flags), 0xC reserved.
// Build option: WB_RESULT_FIFO_RTY_EN makes full-push / empty-pop terminate with rty_o.
module wb_result_fifo #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0200,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        lock_i,
    output logic        err_o,
    output logic        rty_o,
    output logic        ack_o,
    input  logic        tagn_i,
    output logic        tagn_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef WB_RESULT_FIFO_RTY_EN
    localparam bit RTY_EN = 1'b1;
`else
    localparam bit RTY_EN = 1'b0;
`endif

    // HOLD swallows a strobe still held after its termination, so one transfer gets one response.
    typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  ack_q, ack_d, err_q, err_d, rty_q, rty_d;
    logic [31:0]           dat_q, dat_d;
    logic [31:0]           mem_q [DEPTH];
    logic                  req, empty, full, push;
    logic [31:0]           status;
    logic                  unused;

    assign unused = ^{lock_i, tagn_i, addr_i[1:0]};
    assign empty  = cnt_q == '0;
    assign full   = cnt_q[DEPTH_LOG2];
    assign status = {12'h0, udf_q, ovf_q, full, empty, 16'(cnt_q)};
    assign req    = cyc_i & stb_i & (addr_i[31:4] == BASE_ADDR[31:4])
                    & ~(ack_q | err_q | rty_q) & (state_q == IDLE);

    always_comb begin
        state_d = req ? RESP : (state_q != IDLE && cyc_i && stb_i) ? HOLD : IDLE;
        wp_d    = wp_q;
        rp_d    = rp_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rty_d   = 1'b0;
        dat_d   = '0;
        push    = 1'b0;
        if (req) begin
            if (sel_i != 4'hF) begin
                err_d = 1'b1;
            end else begin
                case (addr_i[3:2])
                    2'd0: begin
                        if (we_i) begin
                            if (!full) begin
                                push  = 1'b1;
                                ack_d = 1'b1;
                                wp_d  = wp_q + 1'b1;
                                cnt_d = cnt_q + 1'b1;
                            end else if (RTY_EN) begin
                                rty_d = 1'b1;
                            end else begin
                                ack_d = 1'b1;
                                ovf_d = 1'b1;
                            end
                        end else begin
                            if (!empty) begin
                                ack_d = 1'b1;
                                dat_d = mem_q[rp_q];
                                rp_d  = rp_q + 1'b1;
                                cnt_d = cnt_q - 1'b1;
                            end else if (RTY_EN) begin
                                rty_d = 1'b1;
                            end else begin
                                ack_d = 1'b1;
                                udf_d = 1'b1;
                            end
                        end
                    end
                    2'd1: begin
                        ack_d = 1'b1;
                        dat_d = we_i ? '0 : status;
                    end
                    2'd2: begin
                        ack_d = 1'b1;
                        if (we_i && dat_i[0]) begin
                            wp_d  = '0;
                            rp_d  = '0;
                            cnt_d = '0;
                        end
                        if (we_i && dat_i[1]) begin
                            ovf_d = 1'b0;
                            udf_d = 1'b0;
                        end
                    end
                    default: ack_d = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rty_q   <= rty_d;
            dat_q   <= dat_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i && push) mem_q[wp_q] <= dat_i;
    end

    assign dat_o  = dat_q;
    assign ack_o  = ack_q;
    assign err_o  = err_q;
    assign rty_o  = rty_q;
    assign tagn_o = 1'b0;
endmodule
